// File: rtl/encoder_8x3_priority_sticky.sv
// Sticky 8-to-3 priority encoder with a valid/ready output stage.
// Event pulses on din are held as pending bits and drained one code per
// accepted cycle, highest bit first. Code map matches the 3x8 decoders:
// bit7 -> code 0 ... bit0 -> code 7.
//
// state | meaning
// ------+---------------------------------------------
// EMPTY | no code on dout, dout_valid=0, dout=IDLE_CODE
// FULL  | dout holds a code awaiting dout_ready
module encoder_8x3_priority_sticky #(
    parameter logic [2:0] IDLE_CODE = 3'd0,
    parameter int         CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [7:0]       din,
    output logic [2:0]       dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic [7:0]       pending,
    output logic             overrun,
    output logic [CNT_W-1:0] overrun_cnt
);

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t           state_q;
    logic [2:0]       dout_q;
    logic [7:0]       pending_q, pending_d;
    logic             overrun_q, overrun_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [7:0] set_vec;
    logic [7:0] clr_vec;
    logic [7:0] ovr_vec;
    logic [2:0] pick;
    logic       free;
    logic       load;

    // Highest set pending bit wins; later (higher) indices overwrite earlier ones.
    always_comb begin
        pick = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (pending_q[i]) pick = 3'(i);
        end
    end

    // Pending update, overrun detection and saturating count. A new event on
    // the bit being loaded this edge counts as fresh, so set wins over clear.
    always_comb begin
        set_vec   = din & {8{en}};
        free      = (state_q == EMPTY) || dout_ready;
        load      = free && (|pending_q);
        clr_vec   = load ? (8'b1 << pick) : 8'b0;
        pending_d = (pending_q & ~clr_vec) | set_vec;
        ovr_vec   = set_vec & pending_q & ~clr_vec;
        overrun_d = |ovr_vec;
        cnt_d     = cnt_q;
        if (overrun_d && (cnt_q != CNT_MAX)) cnt_d = cnt_q + 1'b1;
    end

    // Output-stage FSM plus all registered state; stalled FULL holds dout.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= EMPTY;
            dout_q    <= IDLE_CODE;
            pending_q <= 8'h00;
            overrun_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            pending_q <= pending_d;
            overrun_q <= overrun_d;
            cnt_q     <= cnt_d;
            case (state_q)
                EMPTY: begin
                    if (load) begin
                        state_q <= FULL;
                        dout_q  <= 3'd7 - pick;
                    end
                end
                FULL: begin
                    if (load) begin
                        dout_q <= 3'd7 - pick;
                    end else if (dout_ready) begin
                        state_q <= EMPTY;
                        dout_q  <= IDLE_CODE;
                    end
                end
                default: begin
                    state_q <= EMPTY;
                    dout_q  <= IDLE_CODE;
                end
            endcase
        end
    end

    assign dout        = dout_q;
    assign dout_valid  = (state_q == FULL);
    assign pending     = pending_q;
    assign overrun     = overrun_q;
    assign overrun_cnt = cnt_q;

endmodule

// File: tb/tb_encoder_8x3_priority_sticky.sv
// Bench for encoder_8x3_priority_sticky: per-scenario tasks with inline checks,
// plus a scoreboard queue of expected codes consumed on each accepted handshake.
module tb_encoder_8x3_priority_sticky;

    localparam logic [2:0] IDLE = 3'd0;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [7:0] din;
    logic [2:0] dout;
    logic       dout_valid;
    logic       dout_ready;
    logic [7:0] pending;
    logic       overrun;
    logic [7:0] overrun_cnt;

    int checks = 0;
    int errors = 0;
    logic [2:0] exp_q[$];

    encoder_8x3_priority_sticky #(.IDLE_CODE(3'd0), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .en(en), .din(din),
        .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
        .pending(pending), .overrun(overrun), .overrun_cnt(overrun_cnt)
    );

    always #5 clk = ~clk;

    // Scoreboard: every accepted code must match the next expected one.
    always @(negedge clk) begin
        if (rst === 1'b0 && dout_valid === 1'b1 && dout_ready === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected got code %0d, required none", dout);
            end else begin
                logic [2:0] e;
                e = exp_q.pop_front();
                if (dout !== e) begin
                    errors++;
                    $display("FAIL sb_code got %0d, required %0d", dout, e);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b1; din = 8'hFF; dout_ready = 1'b0;
        tick(); tick();
        checks++;
        if (dout_valid !== 1'b0 || dout !== IDLE || pending !== 8'h00 ||
            overrun !== 1'b0 || overrun_cnt !== 8'd0) begin
            errors++;
            $display("FAIL reset got v=%b d=%0d p=%h o=%b c=%0d, required 0/%0d/00/0/0",
                     dout_valid, dout, pending, overrun, overrun_cnt, IDLE);
        end
        rst = 1'b0; din = 8'h00;
        tick();
    endtask

    task automatic test_single();
        dout_ready = 1'b1; en = 1'b1;
        exp_q.push_back(3'd0);
        din = 8'h80;
        tick();
        din = 8'h00;
        checks++;
        if (dout_valid !== 1'b0 || pending !== 8'h80) begin
            errors++;
            $display("FAIL single_t1 got v=%b p=%h, required 0/80", dout_valid, pending);
        end
        tick();
        checks++;
        if (dout_valid !== 1'b1 || dout !== 3'd0) begin
            errors++;
            $display("FAIL single_t2 got v=%b d=%0d, required 1/0", dout_valid, dout);
        end
        tick();
        checks++;
        if (dout_valid !== 1'b0 || dout !== IDLE) begin
            errors++;
            $display("FAIL single_t3 got v=%b d=%0d, required 0/%0d", dout_valid, dout, IDLE);
        end
    endtask

    task automatic test_multi_drain();
        logic [2:0] codes [3] = '{3'd2, 3'd5, 3'd7};
        logic [7:0] pends [3] = '{8'h05, 8'h01, 8'h00};
        dout_ready = 1'b1;
        foreach (codes[k]) exp_q.push_back(codes[k]);
        din = 8'h25;
        tick();
        din = 8'h00;
        checks++;
        if (pending !== 8'h25) begin
            errors++;
            $display("FAIL multi_pend0 got %h, required 25", pending);
        end
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if (dout_valid !== 1'b1 || dout !== codes[k] || pending !== pends[k]) begin
                errors++;
                $display("FAIL multi_step%0d got v=%b d=%0d p=%h, required 1/%0d/%h",
                         k, dout_valid, dout, pending, codes[k], pends[k]);
            end
        end
        tick();
        checks++;
        if (dout_valid !== 1'b0) begin
            errors++;
            $display("FAIL multi_end got v=%b, required 0", dout_valid);
        end
    endtask

    task automatic test_stall();
        dout_ready = 1'b0;
        din = 8'h03;
        tick();
        din = 8'h00;
        tick();
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (dout_valid !== 1'b1 || dout !== 3'd6 || pending !== 8'h01) begin
                errors++;
                $display("FAIL stall_hold%0d got v=%b d=%0d p=%h, required 1/6/01",
                         k, dout_valid, dout, pending);
            end
            tick();
        end
        exp_q.push_back(3'd6);
        exp_q.push_back(3'd7);
        dout_ready = 1'b1;
        tick();
        checks++;
        if (dout_valid !== 1'b1 || dout !== 3'd7 || pending !== 8'h00) begin
            errors++;
            $display("FAIL stall_next got v=%b d=%0d p=%h, required 1/7/00",
                     dout_valid, dout, pending);
        end
        tick();
        checks++;
        if (dout_valid !== 1'b0) begin
            errors++;
            $display("FAIL stall_end got v=%b, required 0", dout_valid);
        end
    endtask

    // Parks code 2 on dout (stalled) with pending[4]=1, then hits bit 4 n times.
    task automatic overrun_burst(input int n);
        dout_ready = 1'b0;
        din = 8'h20;
        tick();
        din = 8'h10;
        tick();
        for (int k = 0; k < n; k++) begin
            tick();
            if (n == 3) begin
                checks++;
                if (overrun !== 1'b1 || overrun_cnt !== 8'(k + 1)) begin
                    errors++;
                    $display("FAIL ovr_pulse%0d got o=%b c=%0d, required 1/%0d",
                             k, overrun, overrun_cnt, k + 1);
                end
            end
        end
        din = 8'h00;
        tick();
        checks++;
        if (overrun !== 1'b0 || pending !== 8'h10 || dout !== 3'd2) begin
            errors++;
            $display("FAIL ovr_after got o=%b p=%h d=%0d, required 0/10/2",
                     overrun, pending, dout);
        end
        exp_q.push_back(3'd2);
        exp_q.push_back(3'd3);
        dout_ready = 1'b1;
        tick(); tick(); tick();
        checks++;
        if (dout_valid !== 1'b0 || pending !== 8'h00) begin
            errors++;
            $display("FAIL ovr_drain got v=%b p=%h, required 0/00", dout_valid, pending);
        end
    endtask

    task automatic test_overrun();
        overrun_burst(3);
        checks++;
        if (overrun_cnt !== 8'd3) begin
            errors++;
            $display("FAIL ovr_cnt3 got %0d, required 3", overrun_cnt);
        end
        overrun_burst(260);
        checks++;
        if (overrun_cnt !== 8'd255) begin
            errors++;
            $display("FAIL ovr_sat got %0d, required 255", overrun_cnt);
        end
    endtask

    task automatic test_en_gating();
        dout_ready = 1'b0; en = 1'b1;
        din = 8'h03;
        tick();
        din = 8'h00;
        tick();
        en = 1'b0; din = 8'hFF;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if (pending !== 8'h01 || overrun !== 1'b0 || dout !== 3'd6) begin
                errors++;
                $display("FAIL en_gate%0d got p=%h o=%b d=%0d, required 01/0/6",
                         k, pending, overrun, dout);
            end
        end
        din = 8'h00; en = 1'b1;
        exp_q.push_back(3'd6);
        exp_q.push_back(3'd7);
        dout_ready = 1'b1;
        tick(); tick(); tick();
    endtask

    task automatic test_set_clear_race();
        dout_ready = 1'b1;
        exp_q.push_back(3'd0);
        exp_q.push_back(3'd0);
        din = 8'h80;
        tick();
        tick();
        din = 8'h00;
        checks++;
        if (dout_valid !== 1'b1 || dout !== 3'd0 || pending !== 8'h80 || overrun !== 1'b0) begin
            errors++;
            $display("FAIL race_load got v=%b d=%0d p=%h o=%b, required 1/0/80/0",
                     dout_valid, dout, pending, overrun);
        end
        tick();
        checks++;
        if (dout_valid !== 1'b1 || dout !== 3'd0 || pending !== 8'h00 || overrun !== 1'b0) begin
            errors++;
            $display("FAIL race_again got v=%b d=%0d p=%h o=%b, required 1/0/00/0",
                     dout_valid, dout, pending, overrun);
        end
        tick();
        checks++;
        if (dout_valid !== 1'b0) begin
            errors++;
            $display("FAIL race_end got v=%b, required 0", dout_valid);
        end
    endtask

    task automatic test_reset_mid();
        dout_ready = 1'b0;
        din = 8'hC0;
        tick();
        din = 8'h00;
        tick();
        checks++;
        if (dout_valid !== 1'b1 || dout !== 3'd0 || pending !== 8'h40) begin
            errors++;
            $display("FAIL rstmid_pre got v=%b d=%0d p=%h, required 1/0/40",
                     dout_valid, dout, pending);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (dout_valid !== 1'b0 || dout !== IDLE || pending !== 8'h00) begin
            errors++;
            $display("FAIL rstmid got v=%b d=%0d p=%h, required 0/%0d/00",
                     dout_valid, dout, pending, IDLE);
        end
        dout_ready = 1'b1;
        tick();
        checks++;
        if (dout_valid !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_post got v=%b, required 0", dout_valid);
        end
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; din = 8'h00; dout_ready = 1'b0;
        test_reset();
        test_single();
        test_multi_drain();
        test_stall();
        test_overrun();
        test_en_gating();
        test_set_clear_race();
        test_reset_mid();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover got %0d codes outstanding, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
